// File: rtl/regfile_cmd_master_pkg.sv
// Shared definitions for the register-file command initiator.
// Provides the datapath widths, the host opcodes and the FSM state
// encoding used by regfile_cmd_master and its command interface.
package regfile_cmd_master_pkg;

  localparam int REG_W  = 16;
  localparam int ADDR_W = 4;

  // Host opcodes
  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_COPY  = 2'd2;
  localparam logic [1:0] OP_SWAP  = 2'd3;

  // FSM state encoding (kept as plain constants for legacy tools)
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_FETCH   = 3'd1;
  localparam state_t ST_CAPTURE = 3'd2;
  localparam state_t ST_WR      = 3'd3;
  localparam state_t ST_WR2     = 3'd4;
  localparam state_t ST_RESP    = 3'd5;

endpackage

// File: rtl/regfile_cmd_master_if.sv
// Host-side command/response channel of regfile_cmd_master.
//   cmd_*  : command channel (valid/ready), host -> initiator
//   rsp_*  : read-response channel (valid/ready), initiator -> host
// Modports: master = host side, slave = regfile_cmd_master side.
interface regfile_cmd_master_if;
  import regfile_cmd_master_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr_a;
  logic [ADDR_W-1:0] cmd_addr_b;
  logic [REG_W-1:0]  cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [REG_W-1:0]  rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/regfile_cmd_master.sv
// Command-driven initiator for the 16x16 register file.
// Accepts WRITE/READ/COPY/SWAP commands from a host and sequences the
// register file's write port (rf_write/rf_DA/rf_D) and read ports
// (rf_AA/rf_BA, 1-cycle registered data on rf_A/rf_B). READ results are
// returned on the response channel. All outputs are registered.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   cmd_if       : command/response channel (slave modport)
//   rf_*         : register file write port, read addresses and read data
module regfile_cmd_master
  import regfile_cmd_master_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  regfile_cmd_master_if.slave        cmd_if,
  output logic                       rf_write,
  output logic [ADDR_W-1:0]          rf_DA,
  output logic [REG_W-1:0]           rf_D,
  output logic [ADDR_W-1:0]          rf_AA,
  output logic [ADDR_W-1:0]          rf_BA,
  input  logic [REG_W-1:0]           rf_A,
  input  logic [REG_W-1:0]           rf_B
);

  state_t            state_r;
  logic [1:0]        op_r;
  logic [ADDR_W-1:0] addr_a_r;
  logic [ADDR_W-1:0] addr_b_r;
  logic [REG_W-1:0]  tmp_r;
  logic              cmd_ready_r;
  logic              rsp_valid_r;
  logic [REG_W-1:0]  rsp_data_r;
  logic              rf_write_r;
  logic [ADDR_W-1:0] rf_da_r;
  logic [REG_W-1:0]  rf_d_r;
  logic [ADDR_W-1:0] rf_aa_r;
  logic [ADDR_W-1:0] rf_ba_r;

  assign cmd_if.cmd_ready = cmd_ready_r;
  assign cmd_if.rsp_valid = rsp_valid_r;
  assign cmd_if.rsp_data  = rsp_data_r;
  assign rf_write         = rf_write_r;
  assign rf_DA            = rf_da_r;
  assign rf_D             = rf_d_r;
  assign rf_AA            = rf_aa_r;
  assign rf_BA            = rf_ba_r;

  // Command FSM with registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_WRITE;
      addr_a_r    <= 4'd0;
      addr_b_r    <= 4'd0;
      tmp_r       <= 16'd0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 16'd0;
      rf_write_r  <= 1'b0;
      rf_da_r     <= 4'd0;
      rf_d_r      <= 16'd0;
      rf_aa_r     <= 4'd0;
      rf_ba_r     <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_if.cmd_valid && cmd_ready_r) begin
            // Latch the whole command so later input changes are ignored.
            op_r        <= cmd_if.cmd_op;
            addr_a_r    <= cmd_if.cmd_addr_a;
            addr_b_r    <= cmd_if.cmd_addr_b;
            cmd_ready_r <= 1'b0;
            case (cmd_if.cmd_op)
              OP_WRITE: begin
                rf_write_r <= 1'b1;
                rf_da_r    <= cmd_if.cmd_addr_a;
                rf_d_r     <= cmd_if.cmd_data;
                state_r    <= ST_WR;
              end
              OP_SWAP: begin
                rf_aa_r <= cmd_if.cmd_addr_a;
                rf_ba_r <= cmd_if.cmd_addr_b;
                state_r <= ST_FETCH;
              end
              default: begin
                // READ and COPY only need port A.
                rf_aa_r <= cmd_if.cmd_addr_a;
                state_r <= ST_FETCH;
              end
            endcase
          end
        end
        ST_FETCH: begin
          // Read address presented; data appears on rf_A/rf_B after this edge.
          state_r <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          case (op_r)
            OP_READ: begin
              rsp_data_r  <= rf_A;
              rsp_valid_r <= 1'b1;
              state_r     <= ST_RESP;
            end
            OP_COPY: begin
              rf_write_r <= 1'b1;
              rf_da_r    <= addr_b_r;
              rf_d_r     <= rf_A;
              state_r    <= ST_WR;
            end
            OP_SWAP: begin
              // rf_A will show the overwritten value next cycle, so keep a copy.
              rf_write_r <= 1'b1;
              rf_da_r    <= addr_a_r;
              rf_d_r     <= rf_B;
              tmp_r      <= rf_A;
              state_r    <= ST_WR2;
            end
            default: begin
              cmd_ready_r <= 1'b1;
              state_r     <= ST_IDLE;
            end
          endcase
        end
        ST_WR2: begin
          // Second SWAP write; rf_write stays asserted.
          rf_da_r <= addr_b_r;
          rf_d_r  <= tmp_r;
          state_r <= ST_WR;
        end
        ST_WR: begin
          rf_write_r  <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
        ST_RESP: begin
          if (cmd_if.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          rf_write_r  <= 1'b0;
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_cmd_master.sv
// Directed self-checking bench for regfile_cmd_master, with a behavioural
// 16x16 register file (registered read ports) attached to its rf_* pins.
module tb_regfile_cmd_master;
  import regfile_cmd_master_pkg::*;

  logic        clock;
  logic        reset;
  logic        rf_write;
  logic [3:0]  rf_DA;
  logic [15:0] rf_D;
  logic [3:0]  rf_AA;
  logic [3:0]  rf_BA;
  logic [15:0] rf_A;
  logic [15:0] rf_B;
  logic [15:0] mem [16];

  int checks = 0;
  int errors = 0;

  regfile_cmd_master_if bus ();

  regfile_cmd_master dut (
    .clock    (clock),
    .reset    (reset),
    .cmd_if   (bus.slave),
    .rf_write (rf_write),
    .rf_DA    (rf_DA),
    .rf_D     (rf_D),
    .rf_AA    (rf_AA),
    .rf_BA    (rf_BA),
    .rf_A     (rf_A),
    .rf_B     (rf_B)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file model: synchronous write, registered reads.
  always @(posedge clock) begin
    if (rf_write) mem[rf_DA] <= rf_D;
    rf_A <= mem[rf_AA];
    rf_B <= mem[rf_BA];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer a command at a negedge; returns at the negedge after the accept edge.
  // Inputs are scrambled afterwards to check that the command was latched.
  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [15:0] d);
    int n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("issue_ready", {15'd0, bus.cmd_ready}, 16'd1);
    bus.cmd_op     = op;
    bus.cmd_addr_a = a;
    bus.cmd_addr_b = b;
    bus.cmd_data   = d;
    bus.cmd_valid  = 1'b1;
    @(negedge clock);
    bus.cmd_valid  = 1'b0;
    bus.cmd_addr_a = ~a;
    bus.cmd_addr_b = ~b;
    bus.cmd_data   = ~d;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    issue(OP_WRITE, a, 4'd0, d);
    chk("wr_pulse", {15'd0, rf_write}, 16'd1);
    chk("wr_da", {12'd0, rf_DA}, {12'd0, a});
    chk("wr_d", rf_D, d);
    @(negedge clock);
    chk("wr_end", {15'd0, rf_write}, 16'd0);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [15:0] exp);
    issue(OP_READ, a, 4'd0, 16'd0);
    chk("rd_e0_valid", {15'd0, bus.rsp_valid}, 16'd0);
    @(negedge clock);
    chk("rd_e1_valid", {15'd0, bus.rsp_valid}, 16'd0);
    @(negedge clock);
    chk("rd_e2_valid", {15'd0, bus.rsp_valid}, 16'd1);
    chk("rd_data", bus.rsp_data, exp);
    @(negedge clock);
    chk("rd_done_valid", {15'd0, bus.rsp_valid}, 16'd0);
    chk("rd_done_ready", {15'd0, bus.cmd_ready}, 16'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("wait_idle", {15'd0, bus.cmd_ready}, 16'd1);
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'd0;
    bus.cmd_addr_a = 4'd0;
    bus.cmd_addr_b = 4'd0;
    bus.cmd_data   = 16'd0;
    bus.rsp_ready  = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Reset state
    chk("rst_cmd_ready", {15'd0, bus.cmd_ready}, 16'd1);
    chk("rst_rsp_valid", {15'd0, bus.rsp_valid}, 16'd0);
    chk("rst_rsp_data", bus.rsp_data, 16'd0);
    chk("rst_rf_write", {15'd0, rf_write}, 16'd0);
    chk("rst_rf_da", {12'd0, rf_DA}, 16'd0);
    chk("rst_rf_d", rf_D, 16'd0);
    chk("rst_rf_aa", {12'd0, rf_AA}, 16'd0);
    chk("rst_rf_ba", {12'd0, rf_BA}, 16'd0);
    reset = 1'b0;
    @(negedge clock);

    // WRITE then back-to-back READ of the same register
    do_write(4'd3, 16'h1234);
    do_read(4'd3, 16'h1234);

    // SWAP(1,2): two consecutive write pulses, 4 busy cycles
    do_write(4'd1, 16'hAAAA);
    do_write(4'd2, 16'h5555);
    issue(OP_SWAP, 4'd1, 4'd2, 16'd0);
    chk("sw_e0_ready", {15'd0, bus.cmd_ready}, 16'd0);
    chk("sw_e0_wr", {15'd0, rf_write}, 16'd0);
    @(negedge clock);
    chk("sw_e1_ready", {15'd0, bus.cmd_ready}, 16'd0);
    chk("sw_e1_wr", {15'd0, rf_write}, 16'd0);
    @(negedge clock);
    chk("sw_e2_ready", {15'd0, bus.cmd_ready}, 16'd0);
    chk("sw_e2_wr", {15'd0, rf_write}, 16'd1);
    chk("sw_e2_da", {12'd0, rf_DA}, 16'd1);
    chk("sw_e2_d", rf_D, 16'h5555);
    @(negedge clock);
    chk("sw_e3_ready", {15'd0, bus.cmd_ready}, 16'd0);
    chk("sw_e3_wr", {15'd0, rf_write}, 16'd1);
    chk("sw_e3_da", {12'd0, rf_DA}, 16'd2);
    chk("sw_e3_d", rf_D, 16'hAAAA);
    @(negedge clock);
    chk("sw_e4_wr", {15'd0, rf_write}, 16'd0);
    chk("sw_e4_ready", {15'd0, bus.cmd_ready}, 16'd1);
    do_read(4'd1, 16'h5555);
    do_read(4'd2, 16'hAAAA);

    // COPY(7,15)
    do_write(4'd7, 16'hBEEF);
    issue(OP_COPY, 4'd7, 4'd15, 16'd0);
    @(negedge clock);
    chk("cp_e1_wr", {15'd0, rf_write}, 16'd0);
    @(negedge clock);
    chk("cp_e2_wr", {15'd0, rf_write}, 16'd1);
    chk("cp_e2_da", {12'd0, rf_DA}, 16'd15);
    chk("cp_e2_d", rf_D, 16'hBEEF);
    @(negedge clock);
    chk("cp_e3_wr", {15'd0, rf_write}, 16'd0);
    chk("cp_e3_ready", {15'd0, bus.cmd_ready}, 16'd1);
    do_read(4'd15, 16'hBEEF);
    do_read(4'd7, 16'hBEEF);

    // READ with 5 cycles of response back-pressure
    bus.rsp_ready = 1'b0;
    issue(OP_READ, 4'd3, 4'd0, 16'd0);
    repeat (2) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {15'd0, bus.rsp_valid}, 16'd1);
      chk("bp_data", bus.rsp_data, 16'h1234);
      chk("bp_cmd_ready", {15'd0, bus.cmd_ready}, 16'd0);
      @(negedge clock);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_valid", {15'd0, bus.rsp_valid}, 16'd0);
    chk("bp_release_ready", {15'd0, bus.cmd_ready}, 16'd1);

    // SWAP and COPY with identical addresses
    do_write(4'd4, 16'h0F0F);
    issue(OP_SWAP, 4'd4, 4'd4, 16'd0);
    wait_idle();
    do_read(4'd4, 16'h0F0F);
    issue(OP_COPY, 4'd4, 4'd4, 16'd0);
    wait_idle();
    do_read(4'd4, 16'h0F0F);

    // Reset during WR2 of a SWAP: only the first write lands
    do_write(4'd8, 16'h1111);
    do_write(4'd9, 16'h2222);
    issue(OP_SWAP, 4'd8, 4'd9, 16'd0);
    repeat (2) @(negedge clock);
    chk("rs_wr2_wr", {15'd0, rf_write}, 16'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("rs_wr", {15'd0, rf_write}, 16'd0);
    chk("rs_ready", {15'd0, bus.cmd_ready}, 16'd1);
    chk("rs_rsp_valid", {15'd0, bus.rsp_valid}, 16'd0);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rs_still_wr", {15'd0, rf_write}, 16'd0);
    do_read(4'd8, 16'h2222);
    do_read(4'd9, 16'h2222);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
